gru_serial_tx: RTL and testbench
================================

# gru_serial_tx

Word-serial transmitter that drives the GRU accelerator's result port (`serial_data_out`, `serial_clk_out`, `serial_valid`) toward the host. It accepts a `DATA_WIDTH`-bit result word from the inference datapath over a valid/ready handshake. It then emits the word MSB-first with a forwarded bit clock, so a host that samples `serial_data_out` on each rising edge of `serial_clk_out` while `serial_valid` is high reconstructs the word exactly. A one-word holding register lets the datapath hand over the next result while the current frame is still shifting.

## Interface
- `DATA_WIDTH`, 32, bits per frame (≥2)
- `CLK_DIV`, 2, system cycles per serial clock half-period (≥1)
- `LEAD_CYCLES`, 4, cycles `serial_valid` is high before bit 0's low phase begins (≥1)
- `GAP_CYCLES`, 8, minimum cycles `serial_valid` is low between frames (≥1)

- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `tx_data`  in  DATA_WIDTH  word to send (IEEE-754 float bits; not interpreted)
- `tx_valid`  in  1  `tx_data` offered
- `tx_ready`  out  1  holding register empty; word accepted when `tx_valid && tx_ready` at a rising edge
- `serial_data_out`  out  1  current bit, MSB first
- `serial_clk_out`  out  1  forwarded bit clock; host samples on its rising edge
- `serial_valid`  out  1  frame envelope
- `tx_busy`  out  1  frame or inter-frame gap in progress
- `tx_done`  out  1  one-cycle pulse at frame end

## Operation
- Storage: shift register `sr`, holding register `hold` with `hold_full` flag, bit counter `0..DATA_WIDTH-1`, phase counter `0..max(CLK_DIV,LEAD_CYCLES,GAP_CYCLES)-1`.
- `tx_ready = !hold_full && !rst`.
- **Accept routing**
  - In IDLE, an accepted word loads `sr` directly.
  - Otherwise it loads `hold` and sets `hold_full`.
- **FSM states:** IDLE, LEAD, LOW, HIGH, TRAIL, GAP.
- **IDLE**
  - Outputs: all serial outputs 0, `tx_busy`=0.
  - On accept, go to LEAD.
- **LEAD**
  - Outputs: `serial_valid`=1, `serial_clk_out`=0, `serial_data_out`=`sr[DATA_WIDTH-1]`.
  - Lasts `LEAD_CYCLES` cycles, then go to LOW.
- **LOW**
  - Outputs: `serial_clk_out`=0, `serial_data_out`=current bit.
  - Lasts `CLK_DIV` cycles, then go to HIGH.
- **HIGH**
  - Outputs: `serial_clk_out`=1, data held unchanged.
  - Lasts `CLK_DIV` cycles.
  - Then shift `sr` left. If the bit just sent was the last bit, go to TRAIL; otherwise go to LOW with the next bit.
- **TRAIL**
  - Outputs: `serial_clk_out`=0, `serial_valid`=1.
  - Lasts `CLK_DIV` cycles.
  - Then go to GAP and assert `tx_done` for that first GAP cycle.
- **GAP**
  - Outputs: `serial_valid`=0, `serial_clk_out`=0, `serial_data_out`=0, `tx_busy`=1.
  - Lasts `GAP_CYCLES` cycles.
  - On exit: if `hold_full`, move `hold`→`sr`, clear `hold_full`, go to LEAD. Otherwise go to IDLE.
- **Simultaneous events**
  - An accept in the same cycle as the GAP→LEAD drain is not possible, because `tx_ready` is 0 while `hold_full`.
  - An accept in the same cycle as GAP→IDLE lands in `hold`, and the next frame starts after one IDLE cycle.
- `tx_data` is ignored unless accepted. A word, once accepted, is sent exactly once.
- **Reset**
  - Effect: from the cycle after `rst` is sampled high, FSM is IDLE, `hold_full`=0, all outputs 0.
  - Mid-frame reset: aborts the frame and discards `sr` and `hold`; no `tx_done`.

## Timing
- All outputs are registered and glitch-free; reset value of every output is 0.
- Word accepted at edge E → `serial_valid`=1 from cycle E+1 (frame cycle 0).
- Bit k (k=0 is the MSB):
  - Rising `serial_clk_out` at frame cycle `LEAD_CYCLES + 2·CLK_DIV·k + CLK_DIV`.
  - Data stable `CLK_DIV` cycles before that edge (`LEAD_CYCLES+CLK_DIV` for k=0) and `CLK_DIV` cycles after it.
- `serial_valid` high for `LEAD_CYCLES + 2·CLK_DIV·DATA_WIDTH + CLK_DIV` cycles; defaults: 4+128+2 = 134.
- `tx_done` is in frame cycle 134 (first cycle with `serial_valid` low).
- Back-to-back frames: `serial_valid` low for exactly `GAP_CYCLES` cycles between frames.
- Exactly `DATA_WIDTH` rising edges of `serial_clk_out` per frame; none outside `serial_valid`.

## Test plan
- **Reset:** assert `rst` 3 cycles while idle and again with `tx_valid`=1 → every output 0 during reset, nothing accepted; `tx_ready`=1 the cycle after release.
- **Single word:** send `0x3F800000` → host sampler on rising `serial_clk_out` recovers `0x3F800000`; 32 edges; `serial_valid` high 134 cycles; `tx_done` one pulse; first edge at frame cycle 6.
- **Back-to-back:** offer `0xDEADBEEF`, then `0x00000001` during bit 5 → second word accepted, `tx_ready`=0 until the first frame's GAP ends; frames separated by exactly 8 low `serial_valid` cycles; both words recovered.
- **Backpressure:** hold `tx_valid`=1 with a third word `0x12345678` while `hold_full` → not accepted until the drain; three frames in order, no loss or duplication.
- **Reset mid-frame:** pulse `rst` at bit 10 of `0xCAFEBABE` → `serial_valid` 0 the next cycle, no `tx_done`; then `0xA5A5A5A5` transmits cleanly.
- **Divider edge:** `CLK_DIV`=1, words `0x00000000` and `0xFFFFFFFF` → 32 edges each; `serial_valid` high 4+64+1 = 69 cycles; values recovered exactly.

Source files
------------

// File: rtl/gru_serial_tx.sv
// Word-serial result transmitter: MSB-first data with a forwarded bit clock and a
// frame envelope, plus a one-word holding register so the next result can queue up.
module gru_serial_tx #(
  parameter int DATA_WIDTH  = 32,
  parameter int CLK_DIV     = 2,
  parameter int LEAD_CYCLES = 4,
  parameter int GAP_CYCLES  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  serial_data_out,
  output logic                  serial_clk_out,
  output logic                  serial_valid,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int PH_MAX0 = (CLK_DIV > LEAD_CYCLES) ? CLK_DIV : LEAD_CYCLES;
  localparam int PH_MAX  = (PH_MAX0 > GAP_CYCLES) ? PH_MAX0 : GAP_CYCLES;
  localparam int PH_W    = $clog2(PH_MAX + 1);
  localparam int BIT_W   = $clog2(DATA_WIDTH);

  localparam logic [PH_W-1:0]  CLK_LAST  = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  LEAD_LAST = PH_W'(LEAD_CYCLES - 1);
  localparam logic [PH_W-1:0]  GAP_LAST  = PH_W'(GAP_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    TRAIL = 3'd4,
    GAP   = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [PH_W-1:0]       ph_q, ph_d;
  logic                  data_q, data_d;
  logic                  sclk_q, sclk_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  accept_s;

  assign tx_ready = !hold_full_q && !rst;
  assign accept_s = tx_valid && tx_ready;

  // Next-state, datapath and next-output computation
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_d       = bit_q;
    ph_d        = ph_q + PH_W'(1);

    // Outside IDLE an accepted word always queues in the holding register.
    if (accept_s && (state_q != IDLE)) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end else begin
      hold_d      = hold_q;
    end

    case (state_q)
      IDLE: begin
        ph_d  = '0;
        bit_d = '0;
        if (hold_full_q) begin
          sr_d        = hold_q;
          hold_full_d = 1'b0;
          state_d     = LEAD;
        end else if (accept_s) begin
          sr_d    = tx_data;
          state_d = LEAD;
        end else begin
          state_d = IDLE;
        end
      end
      LEAD: begin
        if (ph_q == LEAD_LAST) begin
          ph_d    = '0;
          state_d = LOW;
        end else begin
          state_d = LEAD;
        end
      end
      LOW: begin
        if (ph_q == CLK_LAST) begin
          ph_d    = '0;
          state_d = HIGH;
        end else begin
          state_d = LOW;
        end
      end
      HIGH: begin
        if (ph_q == CLK_LAST) begin
          ph_d = '0;
          sr_d = {sr_q[DATA_WIDTH-2:0], 1'b0};
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = TRAIL;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            state_d = LOW;
          end
        end else begin
          state_d = HIGH;
        end
      end
      TRAIL: begin
        if (ph_q == CLK_LAST) begin
          ph_d    = '0;
          state_d = GAP;
        end else begin
          state_d = TRAIL;
        end
      end
      GAP: begin
        if (ph_q == GAP_LAST) begin
          ph_d = '0;
          if (hold_full_q) begin
            sr_d        = hold_q;
            hold_full_d = 1'b0;
            state_d     = LEAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = GAP;
        end
      end
      default: begin
        ph_d    = '0;
        bit_d   = '0;
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they leave the flops glitch-free.
    valid_d = (state_d == LEAD) || (state_d == LOW) || (state_d == HIGH) || (state_d == TRAIL);
    sclk_d  = (state_d == HIGH);
    busy_d  = (state_d != IDLE);
    done_d  = (state_q == TRAIL) && (state_d == GAP);
    case (state_d)
      LEAD, LOW, HIGH: data_d = sr_d[DATA_WIDTH-1];
      TRAIL:           data_d = data_q;
      default:         data_d = 1'b0;
    endcase
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_q       <= '0;
      ph_q        <= '0;
      data_q      <= 1'b0;
      sclk_q      <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_q       <= bit_d;
      ph_q        <= ph_d;
      data_q      <= data_d;
      sclk_q      <= sclk_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign serial_data_out = data_q;
  assign serial_clk_out  = sclk_q;
  assign serial_valid    = valid_q;
  assign tx_busy         = busy_q;
  assign tx_done         = done_q;

endmodule

// File: tb/tb_gru_serial_tx.sv
// Directed bench for gru_serial_tx: a host-side sampler rebuilds each frame and
// the stimulus sequence compares it against hand-computed expectations.
module tb_gru_serial_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] tx_data_a, tx_data_b;
  logic        tx_valid_a, tx_valid_b;
  logic        tx_ready_a, tx_ready_b;
  logic        sdo_a, sclk_a, sv_a, busy_a, done_a;
  logic        sdo_b, sclk_b, sv_b, busy_b, done_b;

  gru_serial_tx u_dut_a (
    .clk(clk), .rst(rst), .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .serial_data_out(sdo_a), .serial_clk_out(sclk_a), .serial_valid(sv_a),
    .tx_busy(busy_a), .tx_done(done_a)
  );

  gru_serial_tx #(.CLK_DIV(1)) u_dut_b (
    .clk(clk), .rst(rst), .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .serial_data_out(sdo_b), .serial_clk_out(sclk_b), .serial_valid(sv_b),
    .tx_busy(busy_b), .tx_done(done_b)
  );

  logic [1:0] sv_w, sc_w, sd_w, dn_w;
  assign sv_w = {sv_b, sv_a};
  assign sc_w = {sclk_b, sclk_a};
  assign sd_w = {sdo_b, sdo_a};
  assign dn_w = {done_b, done_a};

  // Host sampler state (written only by the sampler process)
  logic [1:0]  pv = 2'b00, pc = 2'b00;
  int          cyc = 0;
  int          cur_len[2]   = '{0, 0};
  int          cur_edges[2] = '{0, 0};
  int          first_e[2]   = '{0, 0};
  int          start_c[2]   = '{0, 0};
  int          low_run[2]   = '{0, 0};
  int          gap_last[2]  = '{0, 0};
  int          nfr[2]       = '{0, 0};
  int          done_cnt[2]  = '{0, 0};
  int          done_pos[2]  = '{0, 0};
  int          stray[2]     = '{0, 0};
  logic [31:0] rx[2];
  logic [31:0] fr_word[2][16];
  int          fr_edges[2][16];
  int          fr_len[2][16];
  int          fr_gap[2][16];
  int          fr_first[2][16];

  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (sv_w[i]) begin
        if (!pv[i]) begin
          cur_len[i] = 0; cur_edges[i] = 0; rx[i] = 32'h0; first_e[i] = -1;
          start_c[i] = cyc; gap_last[i] = low_run[i];
        end
        if (sc_w[i] && !pc[i]) begin
          rx[i] = {rx[i][30:0], sd_w[i]};
          if (cur_edges[i] == 0) first_e[i] = cur_len[i];
          cur_edges[i] = cur_edges[i] + 1;
        end
        cur_len[i] = cur_len[i] + 1;
      end else begin
        if (pv[i]) begin
          fr_word[i][nfr[i] % 16]  = rx[i];
          fr_edges[i][nfr[i] % 16] = cur_edges[i];
          fr_len[i][nfr[i] % 16]   = cur_len[i];
          fr_gap[i][nfr[i] % 16]   = gap_last[i];
          fr_first[i][nfr[i] % 16] = first_e[i];
          nfr[i] = nfr[i] + 1;
          low_run[i] = 0;
        end
        low_run[i] = low_run[i] + 1;
        if (sc_w[i] && !pc[i]) stray[i] = stray[i] + 1;
      end
      if (dn_w[i]) begin
        done_cnt[i] = done_cnt[i] + 1;
        done_pos[i] = cyc - start_c[i];
      end
    end
    pv = sv_w;
    pc = sc_w;
  end

  int nchk = 0;
  int npass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int which, input logic [31:0] w, input int budget, input string tag);
    logic ok;
    ok = 1'b0;
    if (which == 0) begin tx_data_a = w; tx_valid_a = 1'b1; end
    else begin tx_data_b = w; tx_valid_b = 1'b1; end
    for (int n = 0; n < budget && !ok; n++) begin
      ok = (which == 0) ? tx_ready_a : tx_ready_b;
      tick();
    end
    if (which == 0) tx_valid_a = 1'b0;
    else tx_valid_b = 1'b0;
    chk(tag, {31'h0, ok}, 32'h1);
  endtask

  task automatic wait_frames(input int which, input int n, input int budget, input string tag);
    for (int k = 0; k < budget && nfr[which] < n; k++) tick();
    chk(tag, {31'h0, nfr[which] >= n}, 32'h1);
  endtask

  task automatic wait_edges(input int which, input int e, input int budget, input string tag);
    for (int k = 0; k < budget && !(sv_w[which] && cur_edges[which] >= e); k++) tick();
    chk(tag, {31'h0, sv_w[which] && cur_edges[which] >= e}, 32'h1);
  endtask

  task automatic wait_idle(input int which, input int budget, input string tag);
    for (int k = 0; k < budget && (which == 0 ? busy_a : busy_b); k++) tick();
    chk(tag, {31'h0, (which == 0 ? busy_a : busy_b)}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, d0;
    rst = 1'b1;
    tx_valid_a = 1'b0; tx_valid_b = 1'b0;
    tx_data_a = 32'h0; tx_data_b = 32'h0;

    // Reset while idle
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_idle_outs", {20'h0, sdo_a, sclk_a, sv_a, busy_a, done_a,
                            sdo_b, sclk_b, sv_b, busy_b, done_b, tx_ready_a, tx_ready_b}, 32'h0);
    end
    rst = 1'b0;
    tick();
    chk("ready_after_rst", {30'h0, tx_ready_a, tx_ready_b}, 32'h3);

    // Reset with tx_valid held high: nothing may be accepted
    rst = 1'b1;
    tx_valid_a = 1'b1; tx_data_a = 32'h11111111;
    tx_valid_b = 1'b1; tx_data_b = 32'h22222222;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_valid_outs", {20'h0, sdo_a, sclk_a, sv_a, busy_a, done_a,
                             sdo_b, sclk_b, sv_b, busy_b, done_b, tx_ready_a, tx_ready_b}, 32'h0);
    end
    rst = 1'b0; tx_valid_a = 1'b0; tx_valid_b = 1'b0;
    tick();
    chk("no_accept_in_rst", {22'h0, sdo_a, sclk_a, sv_a, busy_a, done_a,
                             sdo_b, sclk_b, sv_b, busy_b, done_b}, 32'h0);
    chk("ready_after_rst2", {30'h0, tx_ready_a, tx_ready_b}, 32'h3);

    // Single word
    base = nfr[0]; d0 = done_cnt[0];
    send(0, 32'h3F800000, 4, "acc_single");
    wait_frames(0, base + 1, 400, "single_frame_seen");
    wait_idle(0, 50, "single_idle");
    chk("single_word", fr_word[0][base % 16], 32'h3F800000);
    chk("single_edges", fr_edges[0][base % 16], 32'd32);
    chk("single_len", fr_len[0][base % 16], 32'd134);
    chk("single_first_edge", fr_first[0][base % 16], 32'd6);
    chk("single_done_cnt", done_cnt[0] - d0, 32'd1);
    chk("single_done_pos", done_pos[0], 32'd134);

    // Back-to-back: second word offered during bit 5
    base = nfr[0];
    send(0, 32'hDEADBEEF, 4, "acc_b2b_1");
    wait_edges(0, 5, 200, "b2b_bit5");
    send(0, 32'h00000001, 2, "acc_b2b_2");
    chk("b2b_ready_low_hold", {31'h0, tx_ready_a}, 32'h0);
    for (int k = 0; k < 400 && !done_a; k++) tick();
    chk("b2b_done_seen", {31'h0, done_a}, 32'h1);
    chk("b2b_ready_low_gap", {31'h0, tx_ready_a}, 32'h0);
    wait_frames(0, base + 2, 600, "b2b_frames_seen");
    chk("b2b_ready_after_drain", {31'h0, tx_ready_a}, 32'h1);
    wait_idle(0, 50, "b2b_idle");
    chk("b2b_word1", fr_word[0][base % 16], 32'hDEADBEEF);
    chk("b2b_word2", fr_word[0][(base + 1) % 16], 32'h00000001);
    chk("b2b_gap", fr_gap[0][(base + 1) % 16], 32'd8);
    chk("b2b_edges2", fr_edges[0][(base + 1) % 16], 32'd32);

    // Backpressure: third word held until the holding register drains
    base = nfr[0];
    send(0, 32'hDEADBEEF, 4, "acc_bp_1");
    wait_edges(0, 5, 200, "bp_bit5");
    send(0, 32'h00000001, 2, "acc_bp_2");
    send(0, 32'h12345678, 600, "acc_bp_3");
    chk("bp_third_after_drain", nfr[0] - base, 32'd1);
    chk("bp_second_in_progress", {31'h0, sv_a}, 32'h1);
    wait_frames(0, base + 3, 1000, "bp_frames_seen");
    wait_idle(0, 50, "bp_idle");
    for (int k = 0; k < 5; k++) tick();
    chk("bp_frame_count", nfr[0] - base, 32'd3);
    chk("bp_word1", fr_word[0][base % 16], 32'hDEADBEEF);
    chk("bp_word2", fr_word[0][(base + 1) % 16], 32'h00000001);
    chk("bp_word3", fr_word[0][(base + 2) % 16], 32'h12345678);

    // Reset in the middle of a frame
    d0 = done_cnt[0];
    send(0, 32'hCAFEBABE, 4, "acc_abort");
    wait_edges(0, 10, 200, "abort_bit10");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_outs_zero", {27'h0, sdo_a, sclk_a, sv_a, busy_a, done_a}, 32'h0);
    for (int k = 0; k < 20; k++) tick();
    chk("abort_no_done", done_cnt[0] - d0, 32'd0);
    chk("abort_idle", {31'h0, busy_a}, 32'h0);
    base = nfr[0];
    send(0, 32'hA5A5A5A5, 4, "acc_after_abort");
    wait_frames(0, base + 1, 400, "after_abort_frame");
    chk("after_abort_word", fr_word[0][base % 16], 32'hA5A5A5A5);
    chk("after_abort_edges", fr_edges[0][base % 16], 32'd32);

    // Divider edge: CLK_DIV = 1 instance
    base = nfr[1];
    send(1, 32'h00000000, 4, "acc_div_1");
    send(1, 32'hFFFFFFFF, 4, "acc_div_2");
    wait_frames(1, base + 2, 500, "div_frames_seen");
    chk("div_word1", fr_word[1][base % 16], 32'h00000000);
    chk("div_word2", fr_word[1][(base + 1) % 16], 32'hFFFFFFFF);
    chk("div_edges1", fr_edges[1][base % 16], 32'd32);
    chk("div_edges2", fr_edges[1][(base + 1) % 16], 32'd32);
    chk("div_len1", fr_len[1][base % 16], 32'd69);
    chk("div_len2", fr_len[1][(base + 1) % 16], 32'd69);
    chk("div_gap", fr_gap[1][(base + 1) % 16], 32'd8);

    chk("stray_edges", stray[0] + stray[1], 32'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
